// File: rtl/semaforo_pkg.sv
// Shared types and default timing for the traffic-light lamp sequencer.
// Timing values are in clock cycles.
package semaforo_pkg;

   typedef enum logic [2:0] {
      VERM_NS  = 3'd0,
      NS_VERDE = 3'd1,
      NS_AMAR  = 3'd2,
      VERM_LO  = 3'd3,
      LO_VERDE = 3'd4,
      LO_AMAR  = 3'd5,
      PISCA    = 3'd6
   } estado_t;

   localparam int T_VERDE_MIN_DEF = 8;
   localparam int T_AMARELO_DEF   = 3;
   localparam int T_VERMELHO_DEF  = 2;
   localparam int T_PISCA_DEF     = 4;
   localparam int CNT_W_DEF       = 8;

   typedef struct packed {
      logic verde;
      logic amarelo;
      logic vermelho;
   } lampada_t;

   localparam lampada_t LAMP_VERM  = '{verde: 1'b0, amarelo: 1'b0, vermelho: 1'b1};
   localparam lampada_t LAMP_AMAR  = '{verde: 1'b0, amarelo: 1'b1, vermelho: 1'b0};
   localparam lampada_t LAMP_VERDE = '{verde: 1'b1, amarelo: 1'b0, vermelho: 1'b0};

endpackage

// File: rtl/semaforo_sequenciador_if.sv
// Decision inputs and lamp/debug outputs of the lamp sequencer.
// The slave side is the sequencer; the master side is its environment.
interface semaforo_sequenciador_if;

   logic       ns_sel;
   logic       pisca;
   logic       ns_verde;
   logic       ns_amarelo;
   logic       ns_vermelho;
   logic       lo_verde;
   logic       lo_amarelo;
   logic       lo_vermelho;
   logic [2:0] estado;
   logic       troca;

   modport master (
      output ns_sel, pisca,
      input  ns_verde, ns_amarelo, ns_vermelho,
      input  lo_verde, lo_amarelo, lo_vermelho,
      input  estado, troca
   );

   modport slave (
      input  ns_sel, pisca,
      output ns_verde, ns_amarelo, ns_vermelho,
      output lo_verde, lo_amarelo, lo_vermelho,
      output estado, troca
   );

endinterface

// File: rtl/semaforo_sequenciador_sinc_2ff.sv
// Two-flop synchroniser for a single asynchronous level; both flops reset to 0.
module sinc_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sinc_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sinc_q <= 1'b0;
      end else begin
         meta_q <= d;
         sinc_q <= meta_q;
      end
   end

   assign q = sinc_q;

endmodule

// File: rtl/semaforo_sequenciador.sv
// Lamp sequencer: turns the right-of-way level into green / yellow / all-red
// phases for both approaches, with a flashing-yellow maintenance mode.
module semaforo_sequenciador
   import semaforo_pkg::*;
#(
   parameter int T_VERDE_MIN = T_VERDE_MIN_DEF,
   parameter int T_AMARELO   = T_AMARELO_DEF,
   parameter int T_VERMELHO  = T_VERMELHO_DEF,
   parameter int T_PISCA     = T_PISCA_DEF,
   parameter int CNT_W       = CNT_W_DEF
) (
   input  logic                    clk,
   input  logic                    rst_n,
   semaforo_sequenciador_if.slave  bus
);

   localparam logic [CNT_W-1:0] FIM_VERDE = CNT_W'(T_VERDE_MIN - 1);
   localparam logic [CNT_W-1:0] FIM_AMAR  = CNT_W'(T_AMARELO - 1);
   localparam logic [CNT_W-1:0] FIM_VERM  = CNT_W'(T_VERMELHO - 1);
   localparam logic [CNT_W-1:0] FIM_PISCA = CNT_W'(T_PISCA - 1);

   logic             ns_s;
   logic             pisca_s;
   estado_t          estado_q, estado_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             f_q, f_d;
   logic             alterna;
   lampada_t         ns_lamp_q, ns_lamp_d;
   lampada_t         lo_lamp_q, lo_lamp_d;
   logic             troca_q, troca_d;

   sinc_2ff u_sinc_ns (.clk(clk), .rst_n(rst_n), .d(bus.ns_sel), .q(ns_s));
   sinc_2ff u_sinc_pisca (.clk(clk), .rst_n(rst_n), .d(bus.pisca), .q(pisca_s));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado_q  <= VERM_NS;
         cnt_q     <= '0;
         f_q       <= 1'b0;
         ns_lamp_q <= LAMP_VERM;
         lo_lamp_q <= LAMP_VERM;
         troca_q   <= 1'b0;
      end else begin
         estado_q  <= estado_d;
         cnt_q     <= cnt_d;
         f_q       <= f_d;
         ns_lamp_q <= ns_lamp_d;
         lo_lamp_q <= lo_lamp_d;
         troca_q   <= troca_d;
      end
   end

   // Green only ends on the decision level sampled at or after minimum green;
   // yellow and red phases run purely on the timer.
   always_comb begin
      estado_d = estado_q;
      case (estado_q)
         VERM_NS:  if (cnt_q == FIM_VERM) estado_d = NS_VERDE;
         NS_VERDE: if (cnt_q >= FIM_VERDE && !ns_s) estado_d = NS_AMAR;
         NS_AMAR:  if (cnt_q == FIM_AMAR) estado_d = VERM_LO;
         VERM_LO:  if (cnt_q == FIM_VERM) estado_d = LO_VERDE;
         LO_VERDE: if (cnt_q >= FIM_VERDE && ns_s) estado_d = LO_AMAR;
         LO_AMAR:  if (cnt_q == FIM_AMAR) estado_d = VERM_NS;
         PISCA:    estado_d = VERM_NS;
         default:  estado_d = VERM_NS;
      endcase
      if (pisca_s) estado_d = PISCA;

      alterna = (estado_q == PISCA) && (estado_d == PISCA) && (cnt_q == FIM_PISCA);

      f_d = f_q;
      if (estado_d == PISCA && estado_q != PISCA) f_d = 1'b1;
      else if (alterna)                           f_d = ~f_q;

      // A flash toggle restarts the timer just like a state change does.
      if (estado_d != estado_q || alterna) cnt_d = '0;
      else if (cnt_q != '1)                cnt_d = cnt_q + 1'b1;
      else                                 cnt_d = cnt_q;
   end

   // Lamps are decoded from the next state so the registered outputs line up
   // with estado in the same cycle.
   always_comb begin
      ns_lamp_d = LAMP_VERM;
      lo_lamp_d = LAMP_VERM;
      case (estado_d)
         NS_VERDE: ns_lamp_d = LAMP_VERDE;
         NS_AMAR:  ns_lamp_d = LAMP_AMAR;
         LO_VERDE: lo_lamp_d = LAMP_VERDE;
         LO_AMAR:  lo_lamp_d = LAMP_AMAR;
         PISCA: begin
            ns_lamp_d = '{verde: 1'b0, amarelo: f_d, vermelho: 1'b0};
            lo_lamp_d = '{verde: 1'b0, amarelo: f_d, vermelho: 1'b0};
         end
         default: ;
      endcase
      troca_d = (estado_d == NS_VERDE || estado_d == LO_VERDE) && (estado_d != estado_q);
   end

   assign bus.ns_verde    = ns_lamp_q.verde;
   assign bus.ns_amarelo  = ns_lamp_q.amarelo;
   assign bus.ns_vermelho = ns_lamp_q.vermelho;
   assign bus.lo_verde    = lo_lamp_q.verde;
   assign bus.lo_amarelo  = lo_lamp_q.amarelo;
   assign bus.lo_vermelho = lo_lamp_q.vermelho;
   assign bus.estado      = estado_q;
   assign bus.troca       = troca_q;

endmodule
